// File: rtl/morse_char_buffer.sv
// rtl/morse_char_buffer.sv - Morse character entry buffer with commit, backspace and overflow rejection.
module morse_char_buffer #(
  parameter  int MAX_CHARS = 8,
  parameter  int MAX_SYMS  = 5,
  localparam int CW        = $clog2(MAX_SYMS + 1),
  localparam int PW        = $clog2(MAX_CHARS + 1)
) (
  input  logic                          clk,
  input  logic                          Top_reset,
  input  logic                          Left_dot,
  input  logic                          Mid_dash,
  input  logic                          Right_enter,
  input  logic                          Bot_back,
  output logic [MAX_CHARS*MAX_SYMS-1:0] final_seq_of_in,
  output logic [MAX_CHARS*CW-1:0]       final_num_of_in,
  output logic [PW-1:0]                 char_pos_out,
  output logic [MAX_SYMS-1:0]           cur_seq,
  output logic [CW-1:0]                 cur_num,
  output logic                          buf_full,
  output logic                          err_pulse
);

  typedef enum logic [1:0] {IDLE, ENTRY, FULL} state_t;

  localparam logic [CW-1:0] SYMS_MAX  = CW'(MAX_SYMS);
  localparam logic [PW-1:0] CHARS_MAX = PW'(MAX_CHARS);

  state_t                        r_state, w_state_n;
  logic [MAX_CHARS*MAX_SYMS-1:0] r_seq, w_seq_n;
  logic [MAX_CHARS*CW-1:0]       r_num, w_num_n;
  logic [PW-1:0]                 r_pos, w_pos_n;
  logic [MAX_SYMS-1:0]           r_cur_seq, w_cur_seq_n;
  logic [CW-1:0]                 r_cur_num, w_cur_num_n;
  logic                          r_err, w_err_n;
  logic                          r_dot_q, r_dash_q, r_enter_q, r_back_q;

  logic          w_dot_ev, w_dash_ev, w_enter_ev, w_back_ev;
  logic [CW-1:0] w_cur_dec;
  logic [PW-1:0] w_pos_inc, w_pos_dec;

  // Rising-edge detection: a held button only produces an event on its first cycle.
  assign w_dot_ev   = Left_dot    & ~r_dot_q;
  assign w_dash_ev  = Mid_dash    & ~r_dash_q;
  assign w_enter_ev = Right_enter & ~r_enter_q;
  assign w_back_ev  = Bot_back    & ~r_back_q;

  assign w_cur_dec = r_cur_num - CW'(1);
  assign w_pos_inc = r_pos + PW'(1);
  assign w_pos_dec = r_pos - PW'(1);

  always_ff @(posedge clk or posedge Top_reset) begin
    if (Top_reset) begin
      r_state   <= IDLE;
      r_seq     <= '0;
      r_num     <= '0;
      r_pos     <= '0;
      r_cur_seq <= '0;
      r_cur_num <= '0;
      r_err     <= 1'b0;
      r_dot_q   <= 1'b0;
      r_dash_q  <= 1'b0;
      r_enter_q <= 1'b0;
      r_back_q  <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_seq     <= w_seq_n;
      r_num     <= w_num_n;
      r_pos     <= w_pos_n;
      r_cur_seq <= w_cur_seq_n;
      r_cur_num <= w_cur_num_n;
      r_err     <= w_err_n;
      r_dot_q   <= Left_dot;
      r_dash_q  <= Mid_dash;
      r_enter_q <= Right_enter;
      r_back_q  <= Bot_back;
    end
  end

  // Priority back > enter > symbol; lower-priority events are silently dropped.
  always_comb begin
    w_state_n   = r_state;
    w_seq_n     = r_seq;
    w_num_n     = r_num;
    w_pos_n     = r_pos;
    w_cur_seq_n = r_cur_seq;
    w_cur_num_n = r_cur_num;
    w_err_n     = 1'b0;
    if (w_back_ev) begin
      if (r_state == ENTRY) begin
        w_cur_seq_n[w_cur_dec] = 1'b0;
        w_cur_num_n            = w_cur_dec;
        if (w_cur_dec == '0) w_state_n = IDLE;
      end else if (r_pos != '0) begin
        for (int k = 0; k < MAX_CHARS; k++) begin
          if (PW'(k) == w_pos_dec) begin
            w_seq_n[k*MAX_SYMS +: MAX_SYMS] = '0;
            w_num_n[k*CW +: CW]             = '0;
          end
        end
        w_pos_n   = w_pos_dec;
        w_state_n = IDLE;
      end else begin
        w_err_n = 1'b1;
      end
    end else if (w_enter_ev) begin
      if (r_state == ENTRY) begin
        for (int k = 0; k < MAX_CHARS; k++) begin
          if (PW'(k) == r_pos) begin
            w_seq_n[k*MAX_SYMS +: MAX_SYMS] = r_cur_seq;
            w_num_n[k*CW +: CW]             = r_cur_num;
          end
        end
        w_pos_n     = w_pos_inc;
        w_cur_seq_n = '0;
        w_cur_num_n = '0;
        w_state_n   = (w_pos_inc == CHARS_MAX) ? FULL : IDLE;
      end else begin
        w_err_n = 1'b1;
      end
    end else if (w_dot_ev && w_dash_ev) begin
      w_err_n = 1'b1;
    end else if (w_dot_ev || w_dash_ev) begin
      if (r_state != FULL && r_cur_num < SYMS_MAX) begin
        w_cur_seq_n[r_cur_num] = w_dash_ev;
        w_cur_num_n            = r_cur_num + CW'(1);
        w_state_n              = ENTRY;
      end else begin
        w_err_n = 1'b1;
      end
    end
  end

  assign final_seq_of_in = r_seq;
  assign final_num_of_in = r_num;
  assign char_pos_out    = r_pos;
  assign cur_seq         = r_cur_seq;
  assign cur_num         = r_cur_num;
  assign buf_full        = (r_state == FULL);
  assign err_pulse       = r_err;

endmodule

// File: tb/tb_morse_char_buffer.sv
// tb/tb_morse_char_buffer.sv - Directed self-checking bench for morse_char_buffer (8 chars x 5 symbols).
module tb_morse_char_buffer;

  localparam int MC = 8;
  localparam int MS = 5;
  localparam int CW = 3;
  localparam int PW = 4;

  logic             clk = 1'b0;
  logic             Top_reset = 1'b0;
  logic             Left_dot = 1'b0, Mid_dash = 1'b0, Right_enter = 1'b0, Bot_back = 1'b0;
  logic [MC*MS-1:0] final_seq_of_in;
  logic [MC*CW-1:0] final_num_of_in;
  logic [PW-1:0]    char_pos_out;
  logic [MS-1:0]    cur_seq;
  logic [CW-1:0]    cur_num;
  logic             buf_full, err_pulse;

  int   n_vec = 0;
  int   n_err = 0;
  logic last_err;

  morse_char_buffer #(.MAX_CHARS(MC), .MAX_SYMS(MS)) dut (
    .clk(clk), .Top_reset(Top_reset), .Left_dot(Left_dot), .Mid_dash(Mid_dash),
    .Right_enter(Right_enter), .Bot_back(Bot_back), .final_seq_of_in(final_seq_of_in),
    .final_num_of_in(final_num_of_in), .char_pos_out(char_pos_out), .cur_seq(cur_seq),
    .cur_num(cur_num), .buf_full(buf_full), .err_pulse(err_pulse)
  );

  always #5 clk = ~clk;

  // One-cycle press; last_err holds err_pulse right after the event edge.
  task automatic press(input logic d, input logic s, input logic e, input logic b);
    @(negedge clk);
    Left_dot = d; Mid_dash = s; Right_enter = e; Bot_back = b;
    @(negedge clk);
    last_err = err_pulse;
    Left_dot = 1'b0; Mid_dash = 1'b0; Right_enter = 1'b0; Bot_back = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    Top_reset = 1'b1;
    @(negedge clk);
    Top_reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++; if (final_seq_of_in !== '0 || final_num_of_in !== '0) begin n_err++; $display("FAIL reset_slots: got seq=%h num=%h expected 0", final_seq_of_in, final_num_of_in); end
    n_vec++; if ({char_pos_out, cur_seq, cur_num, buf_full, err_pulse} !== '0) begin n_err++; $display("FAIL reset_state: got pos=%0d seq=%b num=%0d full=%b err=%b expected all 0", char_pos_out, cur_seq, cur_num, buf_full, err_pulse); end
  endtask

  task automatic test_basic_commit();
    press(1, 0, 0, 0);
    press(0, 1, 0, 0);
    n_vec++; if (cur_seq !== 5'b00010 || cur_num !== 3'd2) begin n_err++; $display("FAIL basic_entry: got seq=%b num=%0d expected 00010/2", cur_seq, cur_num); end
    press(0, 0, 1, 0);
    n_vec++; if (final_seq_of_in[0 +: MS] !== 5'b00010 || final_num_of_in[0 +: CW] !== 3'd2) begin n_err++; $display("FAIL basic_slot0: got seq=%b num=%0d expected 00010/2", final_seq_of_in[0 +: MS], final_num_of_in[0 +: CW]); end
    n_vec++; if (char_pos_out !== 4'd1 || cur_num !== 3'd0 || cur_seq !== 5'b0) begin n_err++; $display("FAIL basic_pos: got pos=%0d cur_num=%0d cur_seq=%b expected 1/0/0", char_pos_out, cur_num, cur_seq); end
  endtask

  task automatic test_backspace();
    repeat (3) press(1, 0, 0, 0);
    press(0, 0, 1, 0);
    n_vec++; if (char_pos_out !== 4'd2 || final_num_of_in[CW +: CW] !== 3'd3) begin n_err++; $display("FAIL back_commit1: got pos=%0d num1=%0d expected 2/3", char_pos_out, final_num_of_in[CW +: CW]); end
    press(0, 0, 0, 1);
    n_vec++; if (char_pos_out !== 4'd1 || final_seq_of_in[MS +: MS] !== 5'b0 || final_num_of_in[CW +: CW] !== 3'd0) begin n_err++; $display("FAIL back_uncommit: got pos=%0d seq1=%b num1=%0d expected 1/0/0", char_pos_out, final_seq_of_in[MS +: MS], final_num_of_in[CW +: CW]); end
    n_vec++; if (final_seq_of_in[0 +: MS] !== 5'b00010 || last_err !== 1'b0) begin n_err++; $display("FAIL back_slot0_kept: got seq0=%b err=%b expected 00010/0", final_seq_of_in[0 +: MS], last_err); end
    press(0, 1, 0, 0);
    press(1, 0, 0, 0);
    press(0, 0, 0, 1);
    n_vec++; if (cur_num !== 3'd1 || cur_seq !== 5'b00001) begin n_err++; $display("FAIL back_symbol: got seq=%b num=%0d expected 00001/1", cur_seq, cur_num); end
  endtask

  task automatic test_hold_and_overflow();
    do_reset();
    @(negedge clk); Left_dot = 1'b1;
    repeat (6) @(negedge clk);
    Left_dot = 1'b0;
    @(negedge clk);
    n_vec++; if (cur_num !== 3'd1 || err_pulse !== 1'b0) begin n_err++; $display("FAIL hold_single_event: got num=%0d err=%b expected 1/0", cur_num, err_pulse); end
    press(0, 0, 0, 1);
    press(0, 1, 0, 0);
    repeat (4) press(1, 0, 0, 0);
    n_vec++; if (cur_num !== 3'd5 || cur_seq !== 5'b00001 || last_err !== 1'b0) begin n_err++; $display("FAIL ovf_fill: got num=%0d seq=%b err=%b expected 5/00001/0", cur_num, cur_seq, last_err); end
    press(1, 0, 0, 0);
    n_vec++; if (last_err !== 1'b1) begin n_err++; $display("FAIL ovf_err: got err=%b expected 1", last_err); end
    n_vec++; if (err_pulse !== 1'b0 || cur_num !== 3'd5) begin n_err++; $display("FAIL ovf_pulse_width: got err=%b num=%0d expected 0/5", err_pulse, cur_num); end
    press(0, 0, 1, 0);
    n_vec++; if (final_seq_of_in[0 +: MS] !== 5'b00001 || final_num_of_in[0 +: CW] !== 3'd5) begin n_err++; $display("FAIL ovf_commit: got seq=%b num=%0d expected 00001/5", final_seq_of_in[0 +: MS], final_num_of_in[0 +: CW]); end
  endtask

  task automatic test_full();
    do_reset();
    for (int k = 0; k < MC; k++) begin
      press(1, 0, 0, 0);
      press(0, 1, 0, 0);
      press(0, 0, 1, 0);
    end
    n_vec++; if (buf_full !== 1'b1 || char_pos_out !== 4'd8) begin n_err++; $display("FAIL full_flag: got full=%b pos=%0d expected 1/8", buf_full, char_pos_out); end
    n_vec++; if (final_seq_of_in[7*MS +: MS] !== 5'b00010 || final_num_of_in[7*CW +: CW] !== 3'd2) begin n_err++; $display("FAIL full_slot7: got seq=%b num=%0d expected 00010/2", final_seq_of_in[7*MS +: MS], final_num_of_in[7*CW +: CW]); end
    press(1, 0, 0, 0);
    n_vec++; if (last_err !== 1'b1 || cur_num !== 3'd0 || char_pos_out !== 4'd8) begin n_err++; $display("FAIL full_dot_reject: got err=%b num=%0d pos=%0d expected 1/0/8", last_err, cur_num, char_pos_out); end
    press(0, 0, 1, 0);
    n_vec++; if (last_err !== 1'b1 || char_pos_out !== 4'd8 || buf_full !== 1'b1) begin n_err++; $display("FAIL full_enter_reject: got err=%b pos=%0d full=%b expected 1/8/1", last_err, char_pos_out, buf_full); end
    press(0, 0, 0, 1);
    n_vec++; if (char_pos_out !== 4'd7 || buf_full !== 1'b0 || final_num_of_in[7*CW +: CW] !== 3'd0) begin n_err++; $display("FAIL full_back: got pos=%0d full=%b num7=%0d expected 7/0/0", char_pos_out, buf_full, final_num_of_in[7*CW +: CW]); end
  endtask

  task automatic test_priority();
    do_reset();
    press(1, 0, 0, 0);
    press(0, 1, 0, 0);
    press(0, 0, 1, 1);
    n_vec++; if (cur_num !== 3'd1 || cur_seq !== 5'b0 || char_pos_out !== 4'd0 || last_err !== 1'b0) begin n_err++; $display("FAIL prio_back_enter: got num=%0d seq=%b pos=%0d err=%b expected 1/0/0/0", cur_num, cur_seq, char_pos_out, last_err); end
    press(0, 0, 0, 1);
    press(0, 0, 0, 1);
    n_vec++; if (last_err !== 1'b1 || cur_num !== 3'd0 || char_pos_out !== 4'd0) begin n_err++; $display("FAIL prio_back_empty: got err=%b num=%0d pos=%0d expected 1/0/0", last_err, cur_num, char_pos_out); end
    press(1, 1, 0, 0);
    n_vec++; if (last_err !== 1'b1 || cur_num !== 3'd0) begin n_err++; $display("FAIL prio_dot_dash: got err=%b num=%0d expected 1/0", last_err, cur_num); end
    press(1, 0, 0, 1);
    n_vec++; if (last_err !== 1'b1 || cur_num !== 3'd0) begin n_err++; $display("FAIL prio_back_dot: got err=%b num=%0d expected 1/0", last_err, cur_num); end
  endtask

  task automatic test_async_reset();
    press(0, 1, 0, 0);
    press(1, 0, 0, 0);
    @(negedge clk);
    #2 Top_reset = 1'b1;
    #1;
    n_vec++; if ({final_seq_of_in, final_num_of_in, char_pos_out, cur_seq, cur_num, buf_full, err_pulse} !== '0) begin n_err++; $display("FAIL async_reset: got pos=%0d seq=%b num=%0d expected all 0", char_pos_out, cur_seq, cur_num); end
    Left_dot = 1'b1;
    @(negedge clk);
    Top_reset = 1'b0;
    @(negedge clk);
    n_vec++; if (cur_num !== 3'd1 || cur_seq !== 5'b0) begin n_err++; $display("FAIL held_through_reset: got num=%0d seq=%b expected 1/0", cur_num, cur_seq); end
    Left_dot = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic_commit();
    test_backspace();
    test_hold_and_overflow();
    test_full();
    test_priority();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
